// File: rtl/bridge_n_if.sv
// CPU-side and device-side signal bundle for bridge_n.
// The master modport is the environment (CPU plus devices); the slave modport is the bridge.
interface bridge_n_if #(
    parameter int NDEV = 2
);
    logic                   PrReq;
    logic [31:2]            PrAddr;
    logic [3:0]             PrBE;
    logic [31:0]            PrWD;
    logic                   PrWE;
    logic [31:0]            PrRD;
    logic                   PrReady;
    logic                   PrErr;
    logic [7:2]             HWInt;
    logic [3:2]             HardAddr;
    logic [3:0]             HardBE;
    logic [31:0]            HardWD;
    logic [NDEV-1:0]        HardWE;
    logic [32*NDEV-1:0]     HardRD;
    logic [NDEV-1:0]        IntReq;

    modport master (
        output PrReq, PrAddr, PrBE, PrWD, PrWE, HardRD, IntReq,
        input  PrRD, PrReady, PrErr, HWInt, HardAddr, HardBE, HardWD, HardWE
    );

    modport slave (
        input  PrReq, PrAddr, PrBE, PrWD, PrWE, HardRD, IntReq,
        output PrRD, PrReady, PrErr, HWInt, HardAddr, HardBE, HardWD, HardWE
    );
endinterface

// File: rtl/bridge_n.sv
// CPU-to-device bridge: three-state access FSM, address decode for NDEV device windows
// plus IMASK/IPEND/IMODE control registers, and a level/edge interrupt controller.
module bridge_n #(
    parameter int          NDEV = 2,
    parameter logic [31:0] BASE = 32'h0000_7F00
) (
    input  logic       clk,
    input  logic       rst_n,
    bridge_n_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [31:2]     req_addr_q;
    logic [3:0]      req_be_q;
    logic [31:0]     req_wd_q;
    logic            req_we_q;

    logic [31:0]     prrd_q, prrd_d;
    logic            ready_q, err_q;

    logic [NDEV-1:0] imask_q, imask_d;
    logic [NDEV-1:0] imode_q, imode_d;
    logic [NDEV-1:0] ipend_q, ipend_d;
    logic [NDEV-1:0] sync1_q, sync2_q, sync3_q;
    logic [NDEV-1:0] hwint_q, hwint_d;

    logic [NDEV-1:0] dev_hit, w1c, rise;
    logic [31:0]     offset, rd_data;
    logic            hit_mask, hit_pend, hit_mode, mapped;
    logic            accept, in_access, ctrl_wr;

    assign accept    = (state_q == IDLE) && bus.PrReq;
    assign in_access = (state_q == ACCESS);

    // Decode works on the offset from BASE so an unaligned BASE still lands on 16-byte windows.
    assign offset   = {req_addr_q, 2'b00} - BASE;
    assign hit_mask = (offset == 32'h70);
    assign hit_pend = (offset == 32'h74);
    assign hit_mode = (offset == 32'h78);
    assign mapped   = (|dev_hit) | hit_mask | hit_pend | hit_mode;
    assign ctrl_wr  = in_access & req_we_q & req_be_q[0];

    generate
        for (genvar gi = 0; gi < NDEV; gi++) begin : g_chan
            assign dev_hit[gi] = (offset[31:4] == 28'(gi));
            assign hwint_d[gi] = imask_q[gi] & (imode_q[gi] ? ipend_q[gi] : sync2_q[gi]);
        end
        for (genvar gi = 0; gi < 6; gi++) begin : g_hwint
            if (gi < NDEV) begin : g_used
                assign bus.HWInt[2+gi] = hwint_q[gi];
            end else begin : g_unused
                assign bus.HWInt[2+gi] = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.PrReq) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NDEV; i++) begin
            if (dev_hit[i]) rd_data = bus.HardRD[32*i +: 32];
        end
        if (hit_mask) rd_data = 32'(imask_q);
        if (hit_pend) rd_data = 32'(ipend_q);
        if (hit_mode) rd_data = 32'(imode_q);
    end

    // A pending bit can only exist in edge mode, so masking with the new IMODE also
    // implements the clear-on-mode-change; a new edge overrides a same-cycle W1C.
    always_comb begin
        imask_d = imask_q;
        imode_d = imode_q;
        w1c     = '0;
        if (ctrl_wr && hit_mask) imask_d = req_wd_q[NDEV-1:0];
        if (ctrl_wr && hit_mode) imode_d = req_wd_q[NDEV-1:0];
        if (ctrl_wr && hit_pend) w1c     = req_wd_q[NDEV-1:0];
        rise    = sync2_q & ~sync3_q;
        ipend_d = ((ipend_q & ~w1c) | (rise & imode_q)) & imode_d;
        prrd_d  = (in_access && !req_we_q) ? rd_data : prrd_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            req_addr_q <= '0;
            req_be_q   <= '0;
            req_wd_q   <= '0;
            req_we_q   <= 1'b0;
            prrd_q     <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            imask_q    <= '1;
            imode_q    <= '0;
            ipend_q    <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            sync3_q    <= '0;
            hwint_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                req_addr_q <= bus.PrAddr;
                req_be_q   <= bus.PrBE;
                req_wd_q   <= bus.PrWD;
                req_we_q   <= bus.PrWE;
            end
            prrd_q  <= prrd_d;
            ready_q <= in_access;
            err_q   <= in_access & ~mapped;
            imask_q <= imask_d;
            imode_q <= imode_d;
            ipend_q <= ipend_d;
            sync1_q <= bus.IntReq;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            hwint_q <= hwint_d;
        end
    end

    assign bus.PrRD     = prrd_q;
    assign bus.PrReady  = ready_q;
    assign bus.PrErr    = err_q;
    assign bus.HardAddr = req_addr_q[3:2];
    assign bus.HardBE   = req_be_q;
    assign bus.HardWD   = req_wd_q;
    assign bus.HardWE   = (in_access && req_we_q) ? dev_hit : '0;
endmodule

// File: tb/tb_bridge_n.sv
// Directed bench for bridge_n: accesses push expected responses to a queue that is
// popped and compared when PrReady arrives; interrupt paths are checked directly.
module tb_bridge_n;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bridge_n_if #(.NDEV(2)) bus ();

    bridge_n #(.NDEV(2), .BASE(32'h0000_7F00)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int          ready_cnt = 0;
    int          we_cnt = 0;
    logic [31:0] last_rd = 32'h0;

    always @(negedge clk) begin
        if (bus.PrReady === 1'b1) ready_cnt++;
        if (bus.HardWE !== 2'b00) we_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Called 1 ns after a rising edge; request is sampled at the next edge.
    task automatic drive(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wd);
        bus.PrReq  = 1'b1;
        bus.PrWE   = we;
        bus.PrAddr = addr[31:2];
        bus.PrBE   = be;
        bus.PrWD   = wd;
    endtask

    task automatic finish_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                              input logic [1:0] exp_we);
        int   cyc;
        exp_t e;
        logic [31:0] a;
        a = addr;
        @(posedge clk);
        #1 bus.PrReq = 1'b0;
        @(negedge clk);
        chk("access_hardwe", 32'(bus.HardWE), 32'(exp_we));
        chk("access_hardaddr", 32'(bus.HardAddr), 32'(a[3:2]));
        if (we) chk("access_hardwd", bus.HardWD, wd);
        cyc = 1;
        while (bus.PrReady !== 1'b1 && cyc < 6) begin
            @(negedge clk);
            cyc++;
        end
        chk("latency", 32'(cyc), 32'd2);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("prrd", bus.PrRD, e.rd);
            chk("prerr", 32'(bus.PrErr), 32'(e.err));
        end
        $display("txn we=%0d addr=%h wd=%h rd=%h err=%0d", we, addr, wd, bus.PrRD, bus.PrErr);
        @(negedge clk);
        chk("ready_one_cycle", 32'(bus.PrReady), 32'd0);
    endtask

    task automatic access(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wd, input logic [31:0] exp_rd,
                          input logic exp_err, input logic [1:0] exp_we);
        exp_t e;
        if (!we) last_rd = exp_rd;
        e.rd  = last_rd;
        e.err = exp_err;
        @(posedge clk);
        #1 drive(we, addr, be, wd);
        sb.push_back(e);
        finish_req(we, addr, wd, exp_we);
    endtask

    initial begin
        int cyc;
        int we0, r0;
        exp_t e;
        bus.PrReq  = 1'b0;
        bus.PrWE   = 1'b0;
        bus.PrAddr = '0;
        bus.PrBE   = 4'h0;
        bus.PrWD   = 32'h0;
        bus.HardRD = {32'hDEAD_BEEF, 32'hCAFE_0000};
        bus.IntReq = 2'b00;

        repeat (2) @(negedge clk);
        chk("rst_prrd", bus.PrRD, 32'h0);
        chk("rst_ready", 32'(bus.PrReady), 32'd0);
        chk("rst_err", 32'(bus.PrErr), 32'd0);
        chk("rst_hardwe", 32'(bus.HardWE), 32'd0);
        chk("rst_hwint", 32'(bus.HWInt), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Device reads/writes and unmapped accesses
        access(1'b0, 32'h7F14, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0, 2'b00);
        access(1'b0, 32'h7F00, 4'hF, 32'h0, 32'hCAFE_0000, 1'b0, 2'b00);
        access(1'b1, 32'h7F08, 4'hF, 32'h1234_5678, 32'h0, 1'b0, 2'b01);
        access(1'b1, 32'h7F18, 4'h3, 32'hA5A5_0001, 32'h0, 1'b0, 2'b10);
        access(1'b0, 32'h7F40, 4'hF, 32'h0, 32'h0, 1'b1, 2'b00);
        access(1'b1, 32'h7F40, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b1, 2'b00);
        access(1'b0, 32'h7F70, 4'hF, 32'h0, 32'h3, 1'b0, 2'b00);
        access(1'b0, 32'h7F78, 4'hF, 32'h0, 32'h0, 1'b0, 2'b00);
        access(1'b0, 32'h7F74, 4'hF, 32'h0, 32'h0, 1'b0, 2'b00);
        chk("hwint_idle", 32'(bus.HWInt), 32'd0);

        // Level mode and masking
        bus.IntReq = 2'b10;
        repeat (5) @(negedge clk);
        chk("level_hwint3", 32'(bus.HWInt), 32'h02);
        access(1'b1, 32'h7F70, 4'h1, 32'h1, 32'h0, 1'b0, 2'b00);
        repeat (3) @(negedge clk);
        chk("masked_hwint3", 32'(bus.HWInt), 32'h00);
        access(1'b1, 32'h7F70, 4'hE, 32'h3, 32'h0, 1'b0, 2'b00);
        access(1'b0, 32'h7F70, 4'hF, 32'h0, 32'h1, 1'b0, 2'b00);
        bus.IntReq = 2'b00;
        access(1'b1, 32'h7F70, 4'h1, 32'h3, 32'h0, 1'b0, 2'b00);

        // Edge mode: pulse, hold, W1C
        access(1'b1, 32'h7F78, 4'h1, 32'h1, 32'h0, 1'b0, 2'b00);
        @(posedge clk);
        #1 bus.IntReq = 2'b01;
        @(posedge clk);
        #1 bus.IntReq = 2'b00;
        cyc = 0;
        while (bus.HWInt[2] !== 1'b1 && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        chk("edge_hwint2", 32'(bus.HWInt), 32'h01);
        repeat (6) @(negedge clk);
        chk("edge_hwint2_held", 32'(bus.HWInt), 32'h01);
        access(1'b0, 32'h7F74, 4'hF, 32'h0, 32'h1, 1'b0, 2'b00);
        access(1'b1, 32'h7F74, 4'h1, 32'h1, 32'h0, 1'b0, 2'b00);
        repeat (2) @(negedge clk);
        chk("w1c_hwint2", 32'(bus.HWInt), 32'h00);
        access(1'b0, 32'h7F74, 4'hF, 32'h0, 32'h0, 1'b0, 2'b00);

        // W1C landing on the same edge as a new rising edge: set wins
        @(posedge clk);
        #1 bus.IntReq = 2'b01;
        @(posedge clk);
        #1 drive(1'b1, 32'h7F74, 4'h1, 32'h1);
        e.rd = last_rd;
        e.err = 1'b0;
        sb.push_back(e);
        finish_req(1'b1, 32'h7F74, 32'h1, 2'b00);
        bus.IntReq = 2'b00;
        access(1'b0, 32'h7F74, 4'hF, 32'h0, 32'h1, 1'b0, 2'b00);
        access(1'b1, 32'h7F78, 4'h1, 32'h0, 32'h0, 1'b0, 2'b00);
        access(1'b0, 32'h7F74, 4'hF, 32'h0, 32'h0, 1'b0, 2'b00);

        // Request held high through RESP is accepted again
        @(posedge clk);
        #1 drive(1'b0, 32'h7F14, 4'hF, 32'h0);
        r0 = ready_cnt;
        @(posedge clk);
        repeat (6) @(negedge clk);
        bus.PrReq = 1'b0;
        #1 chk("held_req_completions", 32'(ready_cnt - r0), 32'd2);
        last_rd = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);

        // Reset in the ACCESS cycle of a write aborts it
        @(posedge clk);
        #1 drive(1'b1, 32'h7F08, 4'hF, 32'h5555_AAAA);
        @(posedge clk);
        #1 begin
            bus.PrReq = 1'b0;
            rst_n = 1'b0;
        end
        we0 = we_cnt;
        r0 = ready_cnt;
        repeat (3) @(negedge clk);
        chk("abort_hardwe", 32'(bus.HardWE), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #1 chk("abort_we_pulses", 32'(we_cnt - we0), 32'd0);
        chk("abort_ready_pulses", 32'(ready_cnt - r0), 32'd0);
        chk("abort_prrd_reset", bus.PrRD, 32'h0);
        last_rd = 32'h0;
        access(1'b0, 32'h7F14, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0, 2'b00);
        access(1'b0, 32'h7F70, 4'hF, 32'h0, 32'h3, 1'b0, 2'b00);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
